// File: rtl/enc128_scan.sv
// Scans a 128-bit request word and emits one 7-bit set-bit index per output beat; first beat one cycle after accept.
// Output beats hold while out_ready is low; no new word is accepted until the current word's last beat completes.
module enc128_scan #(
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [6:0]   dataout,
  output logic         out_last,
  output logic         out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] pend_q, pend_d;
  logic         zero_flag_q, zero_flag_d;

  logic [6:0]   pick_idx;
  logic         pend_single;
  logic         beat;

  // Later loop iterations overwrite earlier ones, so the scan direction selects the priority end.
  always_comb begin
    pick_idx = 7'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 127; i >= 0; i--) begin
        if (pend_q[i]) pick_idx = 7'(i);
      end
    end else begin
      for (int i = 0; i < 128; i++) begin
        if (pend_q[i]) pick_idx = 7'(i);
      end
    end
  end

  assign pend_single = (pend_q != 128'd0) && ((pend_q & (pend_q - 128'd1)) == 128'd0);

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dataout   = 7'd0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_zero  = zero_flag_q;
        out_last  = zero_flag_q | pend_single;
        dataout   = zero_flag_q ? 7'd0 : pick_idx;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign beat = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d      = datain;
          zero_flag_d = (datain == 128'd0);
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (beat) begin
          pend_d = pend_q & ~(128'd1 << pick_idx);
          if (out_last) begin
            state_d     = IDLE;
            pend_d      = 128'd0;
            zero_flag_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 128'd0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zero_flag_q <= zero_flag_d;
    end
  end

endmodule
